// File: rtl/instr_encoder.sv
// MIPS-subset instruction encoder feeding an instruction-memory write port.
// Each accepted descriptor is encoded into a 32-bit word and written to the
// next memory slot; the write pointer wraps after 256 words and the encoder
// then stalls in FULL until cleared.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a descriptor (inReady=1)
//   WRITE | memWrite=1 for one cycle at memAddr = write pointer
//   FULL  | 256 words written; descriptors ignored until clear/reset
module instr_encoder (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        inValid,
   output logic        inReady,
   input  logic [4:0]  opSel,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic        memWrite,
   output logic [7:0]  memAddr,
   output logic [31:0] memData,
   output logic [8:0]  count,
   output logic        full,
   output logic        errFlag
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [4:0] OP_SLL = 5'd7;
   localparam logic [4:0] OP_SRL = 5'd8;
   localparam logic [4:0] OP_JR  = 5'd11;
   localparam logic [4:0] OP_LUI = 5'd15;

   state_t      state_q;
   logic [7:0]  ptr_q;
   logic [8:0]  count_q;
   logic        mem_write_q;
   logic [31:0] mem_data_q;
   logic        err_q;

   logic        legal_d;
   logic        rtype_d;
   logic        jtype_d;
   logic [5:0]  opcode_d;
   logic [5:0]  funct_d;
   logic [4:0]  f_rs_d;
   logic [4:0]  f_rt_d;
   logic [4:0]  f_rd_d;
   logic [4:0]  f_sh_d;
   logic [31:0] enc_d;

   // Decode opSel into format, opcode/funct and legality.
   always_comb begin
      legal_d  = 1'b1;
      rtype_d  = 1'b0;
      jtype_d  = 1'b0;
      opcode_d = 6'b000000;
      funct_d  = 6'b000000;
      case (opSel)
         5'd0:  begin rtype_d = 1'b1; funct_d = 6'b100000; end // add
         5'd1:  begin rtype_d = 1'b1; funct_d = 6'b100001; end // addu
         5'd2:  begin rtype_d = 1'b1; funct_d = 6'b100100; end // and
         5'd3:  begin rtype_d = 1'b1; funct_d = 6'b100111; end // nor
         5'd4:  begin rtype_d = 1'b1; funct_d = 6'b100101; end // or
         5'd5:  begin rtype_d = 1'b1; funct_d = 6'b101010; end // slt
         5'd6:  begin rtype_d = 1'b1; funct_d = 6'b101011; end // sltu
         5'd7:  begin rtype_d = 1'b1; funct_d = 6'b000000; end // sll
         5'd8:  begin rtype_d = 1'b1; funct_d = 6'b000010; end // srl
         5'd9:  begin rtype_d = 1'b1; funct_d = 6'b100010; end // sub
         5'd10: begin rtype_d = 1'b1; funct_d = 6'b100011; end // subu
         5'd11: begin rtype_d = 1'b1; funct_d = 6'b001000; end // jr
         5'd12: opcode_d = 6'b100100; // lbu
         5'd13: opcode_d = 6'b100101; // lhu
         5'd14: opcode_d = 6'b110000; // ll
         5'd15: opcode_d = 6'b001111; // lui
         5'd16: opcode_d = 6'b100011; // lw
         5'd17: opcode_d = 6'b101000; // sb
         5'd18: opcode_d = 6'b101001; // sh
         5'd19: opcode_d = 6'b101011; // sw
         5'd20: opcode_d = 6'b001000; // addi
         5'd21: opcode_d = 6'b001001; // addiu
         5'd22: opcode_d = 6'b001100; // andi
         5'd23: opcode_d = 6'b001101; // ori
         5'd24: opcode_d = 6'b001010; // slti
         5'd25: opcode_d = 6'b001011; // sltiu
         5'd26: opcode_d = 6'b000100; // beq
         5'd27: opcode_d = 6'b000101; // bne
         5'd28: begin jtype_d = 1'b1; opcode_d = 6'b000011; end // jal
         5'd29: begin jtype_d = 1'b1; opcode_d = 6'b000010; end // j
         default: legal_d = 1'b0;
      endcase
   end

   // Zero the fields an op does not use, then assemble the word.
   always_comb begin
      f_rs_d = rs;
      f_rt_d = rt;
      f_rd_d = rd;
      f_sh_d = 5'd0;
      if (opSel == OP_SLL || opSel == OP_SRL) begin
         f_rs_d = 5'd0;
         f_sh_d = shamt;
      end
      if (opSel == OP_JR) begin
         f_rt_d = 5'd0;
         f_rd_d = 5'd0;
      end
      if (opSel == OP_LUI) begin
         f_rs_d = 5'd0;
      end
      if (rtype_d) begin
         enc_d = {6'b000000, f_rs_d, f_rt_d, f_rd_d, f_sh_d, funct_d};
      end else if (jtype_d) begin
         enc_d = {opcode_d, target};
      end else begin
         enc_d = {opcode_d, f_rs_d, f_rt_d, imm};
      end
   end

   // Sequencer: accept, write one cycle, advance pointer/count, stall when full.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= 8'd0;
         count_q     <= 9'd0;
         mem_write_q <= 1'b0;
         mem_data_q  <= 32'd0;
         err_q       <= 1'b0;
      end else if (clear) begin
         // A write in flight has already been presented for its full cycle.
         state_q     <= IDLE;
         ptr_q       <= 8'd0;
         count_q     <= 9'd0;
         mem_write_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (inValid) begin
                  if (legal_d) begin
                     mem_data_q  <= enc_d;
                     mem_write_q <= 1'b1;
                     state_q     <= WRITE;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            WRITE: begin
               mem_write_q <= 1'b0;
               ptr_q       <= ptr_q + 8'd1;
               count_q     <= count_q + 9'd1;
               if (count_q == 9'd255) begin
                  state_q <= FULL;
               end else begin
                  state_q <= IDLE;
               end
            end
            FULL: begin
               state_q <= FULL;
            end
            default: begin
               state_q     <= IDLE;
               mem_write_q <= 1'b0;
            end
         endcase
      end
   end

   assign inReady  = (state_q == IDLE);
   assign full     = (state_q == FULL);
   assign memWrite = mem_write_q;
   assign memAddr  = ptr_q;
   assign memData  = mem_data_q;
   assign count    = count_q;
   assign errFlag  = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed and random descriptors checked against
// a table-driven reference encoder and a simple pointer/count model.
module tb_instr_encoder;

   logic        clock = 1'b0;
   logic        reset, clear, inValid;
   logic        inReady;
   logic [4:0]  opSel, rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [25:0] target;
   logic        memWrite;
   logic [7:0]  memAddr;
   logic [31:0] memData;
   logic [8:0]  count;
   logic        full, errFlag;

   int checks = 0;
   int fails  = 0;

   // model state
   int unsigned m_ptr   = 0;
   int unsigned m_count = 0;
   int unsigned m_err   = 0;
   int unsigned m_data  = 0;

   int unsigned rfun [12] = '{32, 33, 36, 39, 37, 42, 43, 0, 2, 34, 35, 8};
   int unsigned iopc [16] = '{36, 37, 48, 15, 35, 40, 41, 43, 8, 9, 12, 13, 10, 11, 4, 5};

   instr_encoder dut (
      .clock(clock), .reset(reset), .clear(clear), .inValid(inValid),
      .inReady(inReady), .opSel(opSel), .rs(rs), .rt(rt), .rd(rd),
      .shamt(shamt), .imm(imm), .target(target), .memWrite(memWrite),
      .memAddr(memAddr), .memData(memData), .count(count), .full(full),
      .errFlag(errFlag)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference encoding computed arithmetically from field positions.
   function automatic int unsigned ref_enc(input int unsigned op, input int unsigned s,
         input int unsigned t, input int unsigned d, input int unsigned sa,
         input int unsigned im, input int unsigned tg, output bit legal);
      legal = 1'b1;
      if (op <= 11) begin
         if (op == 7 || op == 8) s = 0; else sa = 0;
         if (op == 11) begin t = 0; d = 0; sa = 0; end
         return rfun[op] + sa * 64 + d * 2048 + t * 65536 + s * 2097152;
      end else if (op <= 27) begin
         if (op == 15) s = 0;
         return iopc[op - 12] * 67108864 + s * 2097152 + t * 65536 + im;
      end else if (op == 28) begin
         return 3 * 67108864 + tg;
      end else if (op == 29) begin
         return 2 * 67108864 + tg;
      end
      legal = 1'b0;
      return 0;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_fields(input int unsigned op, input int unsigned s, input int unsigned t,
         input int unsigned d, input int unsigned sa, input int unsigned im, input int unsigned tg);
      opSel = op[4:0]; rs = s[4:0]; rt = t[4:0]; rd = d[4:0];
      shamt = sa[4:0]; imm = im[15:0]; target = tg[25:0];
   endtask

   // Present one descriptor in IDLE and follow it through to completion.
   task automatic send(input int unsigned op, input int unsigned s, input int unsigned t,
         input int unsigned d, input int unsigned sa, input int unsigned im, input int unsigned tg);
      bit legal;
      int unsigned w;
      w = ref_enc(op, s, t, d, sa, im, tg, legal);
      chk("ready_before", {31'd0, inReady}, 32'd1);
      set_fields(op, s, t, d, sa, im, tg);
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      if (legal) begin
         m_data = w;
         chk("wr_pulse", {31'd0, memWrite}, 32'd1);
         chk("wr_addr", {24'd0, memAddr}, m_ptr);
         chk("wr_data", memData, m_data);
         chk("busy", {31'd0, inReady}, 32'd0);
         tick();
         m_ptr   = (m_ptr + 1) % 256;
         m_count = m_count + 1;
         chk("wr_end", {31'd0, memWrite}, 32'd0);
         chk("count", {23'd0, count}, m_count);
         chk("full", {31'd0, full}, (m_count == 256) ? 32'd1 : 32'd0);
         chk("ready_after", {31'd0, inReady}, (m_count == 256) ? 32'd0 : 32'd1);
      end else begin
         m_err = 1;
         chk("ill_nowrite", {31'd0, memWrite}, 32'd0);
         chk("ill_count", {23'd0, count}, m_count);
         chk("ill_data", memData, m_data);
         chk("ill_ready", {31'd0, inReady}, 32'd1);
      end
      chk("err", {31'd0, errFlag}, m_err);
   endtask

   initial begin
      bit lg;
      int unsigned op;
      int guard;
      reset = 1'b1; clear = 1'b0; inValid = 1'b0;
      set_fields(0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("rst_memWrite", {31'd0, memWrite}, 32'd0);
      chk("rst_memAddr", {24'd0, memAddr}, 32'd0);
      chk("rst_memData", memData, 32'd0);
      chk("rst_count", {23'd0, count}, 32'd0);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_err", {31'd0, errFlag}, 32'd0);
      chk("rst_ready", {31'd0, inReady}, 32'd1);
      reset = 1'b0;

      // add r3, r1, r2
      send(0, 1, 2, 3, 0, 0, 0);
      chk("add_word", memData, 32'h00221820);

      // restart, then lw and j land at 0 and 1
      clear = 1'b1;
      tick();
      clear = 1'b0;
      m_ptr = 0; m_count = 0; m_err = 0;
      chk("clr_count", {23'd0, count}, 32'd0);
      chk("clr_hold_data", memData, 32'h00221820);
      send(16, 29, 8, 0, 0, 16'h0004, 0);
      chk("lw_word", memData, 32'h8FA80004);
      send(29, 0, 0, 0, 0, 0, 26'h0100000);
      chk("j_word", memData, 32'h08100000);

      // illegal ops: sticky error, no write
      send(30, 1, 2, 3, 4, 5, 6);
      send(31, 7, 7, 7, 7, 7, 7);
      send(7, 9, 4, 5, 3, 16'hFFFF, 0);   // sll with rs forced to zero
      send(11, 31, 9, 8, 2, 0, 0);        // jr keeps only rs
      send(15, 12, 6, 0, 0, 16'h1234, 0); // lui with rs forced to zero

      // clear wins over a simultaneous handshake
      set_fields(0, 1, 1, 1, 0, 0, 0);
      inValid = 1'b1; clear = 1'b1;
      tick();
      inValid = 1'b0; clear = 1'b0;
      m_ptr = 0; m_count = 0; m_err = 0;
      chk("clrhs_nowrite", {31'd0, memWrite}, 32'd0);
      chk("clrhs_count", {23'd0, count}, 32'd0);
      chk("clrhs_err", {31'd0, errFlag}, 32'd0);
      chk("clrhs_data", memData, m_data);

      // random mix including illegal codes
      for (int i = 0; i < 40; i++) begin
         send($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
              $urandom & 32'h03FF_FFFF);
      end

      // fill to 256 with random legal ops
      guard = 0;
      while (m_count < 256 && guard < 300) begin
         send($urandom_range(0, 29), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
              $urandom & 32'h03FF_FFFF);
         guard++;
      end
      chk("fill_count", {23'd0, count}, 32'd256);
      chk("fill_full", {31'd0, full}, 32'd1);
      chk("fill_ready", {31'd0, inReady}, 32'd0);
      chk("fill_wrap", {24'd0, memAddr}, 32'd0);

      // 257th descriptor ignored
      set_fields(1, 1, 2, 3, 0, 0, 0);
      inValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("full_nowrite", {31'd0, memWrite}, 32'd0);
         chk("full_count", {23'd0, count}, 32'd256);
      end
      inValid = 1'b0;

      clear = 1'b1;
      tick();
      clear = 1'b0;
      m_ptr = 0; m_count = 0; m_err = 0;
      chk("unfull_count", {23'd0, count}, 32'd0);
      chk("unfull_full", {31'd0, full}, 32'd0);
      send(21, 3, 4, 0, 0, 16'h8001, 0);

      // clear during WRITE
      set_fields(4, 5, 6, 7, 0, 0, 0);
      m_data = ref_enc(4, 5, 6, 7, 0, 0, 0, lg);
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      clear = 1'b1;
      chk("cw_pulse", {31'd0, memWrite}, 32'd1);
      chk("cw_addr", {24'd0, memAddr}, 32'd1);
      tick();
      clear = 1'b0;
      m_ptr = 0; m_count = 0; m_err = 0;
      chk("cw_drop", {31'd0, memWrite}, 32'd0);
      chk("cw_ptr", {24'd0, memAddr}, 32'd0);
      chk("cw_count", {23'd0, count}, 32'd0);
      chk("cw_data", memData, m_data);
      chk("cw_ready", {31'd0, inReady}, 32'd1);

      // reset during WRITE
      send(2, 1, 1, 1, 0, 0, 0);
      op = 20;
      set_fields(op, 1, 2, 0, 0, 16'h00FF, 0);
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      reset = 1'b1;
      chk("rw_pulse", {31'd0, memWrite}, 32'd1);
      tick();
      reset = 1'b0;
      chk("rw_drop", {31'd0, memWrite}, 32'd0);
      chk("rw_ptr", {24'd0, memAddr}, 32'd0);
      chk("rw_count", {23'd0, count}, 32'd0);
      chk("rw_data", memData, 32'd0);
      chk("rw_ready", {31'd0, inReady}, 32'd1);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, highest priority.
REQ-003 SHALL have port clear, input, 1, synchronous restart of write pointer, count and errFlag.
REQ-004 SHALL have port inValid, input, 1, instruction descriptor present.
REQ-005 SHALL have port inReady, output, 1, encoder can accept a descriptor this cycle.
REQ-006 SHALL have port opSel, input, 5, mnemonic index per REQ-013.
REQ-007 SHALL have ports rs, rt, rd and shamt, each input, 5, register and shift fields.
REQ-008 SHALL have ports imm, input, 16, and target, input, 26, immediate and jump fields.
REQ-009 SHALL have ports memWrite, output, 1; memAddr, output, 8; and memData, output, 32; these form the instruction-memory word write port.
REQ-010 SHALL have ports count, output, 9, words written (0..256); full, output, 1; and errFlag, output, 1, sticky illegal-opSel flag.

Function
REQ-011 SHALL implement the FSM states IDLE, WRITE and FULL.
REQ-012 SHALL accept a descriptor on a rising edge where inValid=1 and inReady=1; inReady=1 only in IDLE; in IDLE, inValid=0 keeps the state IDLE.
REQ-013 SHALL use this opSel map: 0 add, 1 addu, 2 and, 3 nor, 4 or, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sub, 10 subu, 11 jr, 12 lbu, 13 lhu, 14 ll, 15 lui, 16 lw, 17 sb, 18 sh, 19 sw, 20 addi, 21 addiu, 22 andi, 23 ori, 24 slti, 25 sltiu, 26 beq, 27 bne, 28 jal, 29 j; 30 and 31 are illegal.
REQ-014 SHALL encode R-type (ops 0-11) as opcode 000000|rs|rt|rd|shamt|funct with these funct values: add 100000, addu 100001, and 100100, nor 100111, or 100101, slt 101010, sltu 101011, sll 000000, srl 000010, sub 100010, subu 100011, jr 001000.
REQ-015 SHALL force shamt=0 for R-type ops other than sll/srl, force rs=0 for sll/srl, and force rt=rd=shamt=0 for jr.
REQ-016 SHALL encode I-type as opcode|rs|rt|imm with these opcodes: lbu 100100, lhu 100101, ll 110000, lui 001111 (rs forced 0), lw 100011, sb 101000, sh 101001, sw 101011, addi 001000, addiu 001001, andi 001100, ori 001101, slti 001010, sltiu 001011, beq 000100, bne 000101.
REQ-017 SHALL encode J-type as opcode|target with jal 000011 and j 000010.
REQ-018 SHALL, on acceptance of a legal op, register the encoded word into memData and enter WRITE on the same edge, giving one-cycle latency.
REQ-019 SHALL, in WRITE, drive memWrite=1 for exactly one cycle with memAddr equal to the write pointer; memWrite=0 in all other states.
REQ-020 SHALL, on the edge leaving WRITE, increment the pointer and count; if count becomes 256 it SHALL go to FULL with the pointer wrapped to 0, otherwise to IDLE.
REQ-021 SHALL give a throughput of at most one descriptor per 2 cycles.
REQ-022 SHALL, on acceptance of an illegal op, set errFlag=1 on the next edge, stay in IDLE, perform no write, and leave count and memData unchanged.
REQ-023 SHALL, in FULL, drive full=1 and inReady=0, ignore inValid, and exit only on clear or reset.
REQ-024 SHALL, when clear is sampled, set the state to IDLE and the pointer, count and errFlag to 0; memData SHALL hold.
REQ-025 SHALL, when clear is sampled in WRITE, still complete that cycle's write (memWrite was high for the whole cycle); the pointer SHALL then go to 0, not increment.
REQ-026 SHALL give clear priority over a simultaneous handshake in IDLE: the descriptor is dropped.

Reset
REQ-027 SHALL, with reset=1 at an edge, set state IDLE, memWrite 0, memAddr 0, memData 0, count 0, full 0, errFlag 0, so that inReady=1 in the following cycle.
REQ-028 SHALL, on reset during WRITE, clear memWrite from the next cycle and leave count unincremented.

Verification
REQ-029 SHALL cover: reset asserted for 2 cycles -> all outputs 0 and inReady=1.
REQ-030 SHALL cover: opSel=0 (add), rs=1, rt=2, rd=3 -> next cycle memWrite=1, memAddr=0, memData=0x00221820; then count=1.
REQ-031 SHALL cover: lw (16), rs=29, rt=8, imm=0x0004, then j (29), target=0x0100000 -> memData 0x8FA80004 at memAddr 0, then 0x08100000 at memAddr 1.
REQ-032 SHALL cover: opSel=30 -> errFlag=1, no memWrite pulse, count unchanged, inReady=1 next cycle.
REQ-033 SHALL cover: 256 back-to-back legal ops -> full=1, count=256, inReady=0, and a 257th inValid ignored; then clear -> count=0, full=0, and the next write lands at memAddr 0.
REQ-034 SHALL cover: clear and reset each asserted during WRITE -> memWrite drops the following cycle, and the pointer is 0 afterwards.
